// File: rtl/bp_fe_bp_tournament_gshare.sv
// bp_fe_bp_tournament_gshare: tournament (local/gshare/chooser) direction predictor with speculative GHR and repair
module bp_fe_bp_tournament_gshare #(
  parameter int bht_idx_width_p = 8,
  parameter int ghist_width_p = 8,
  parameter int bp_cnt_sat_bits_p = 2,
  localparam int meta_width_lp = ghist_width_p + 2
) (
  input  logic                       clk_i,
  input  logic                       reset_n_i,
  input  logic                       r_v_i,
  input  logic [bht_idx_width_p-1:0] idx_r_i,
  output logic                       predict_v_o,
  output logic                       predict_o,
  output logic [meta_width_lp-1:0]   meta_o,
  input  logic                       w_v_i,
  input  logic [bht_idx_width_p-1:0] idx_w_i,
  input  logic                       taken_i,
  input  logic                       mispredict_i,
  input  logic [meta_width_lp-1:0]   meta_i
);
  localparam int entries_lp = 2 ** bht_idx_width_p;
  localparam logic [bp_cnt_sat_bits_p-1:0] half_lp = {1'b0, {(bp_cnt_sat_bits_p-1){1'b1}}};
  logic [bp_cnt_sat_bits_p-1:0] lbht_r [entries_lp];
  logic [bp_cnt_sat_bits_p-1:0] gbht_r [entries_lp];
  logic [bp_cnt_sat_bits_p-1:0] chooser_r [entries_lp];
  logic [ghist_width_p-1:0] ghr_r, ghist_w, ghr_shift, ghr_repair;
  logic [bht_idx_width_p-1:0] gidx_r, gidx_w;
  logic pl, pg, pred, accept, repair, pl_w, pg_w;
  function automatic logic [bp_cnt_sat_bits_p-1:0] sat(input logic [bp_cnt_sat_bits_p-1:0] c, input logic up);
    return up ? (&c ? c : c + bp_cnt_sat_bits_p'(1)) : (|c ? c - bp_cnt_sat_bits_p'(1) : c);
  endfunction
  always_comb begin
    gidx_r = idx_r_i ^ bht_idx_width_p'(ghr_r);
    pl = lbht_r[idx_r_i] > half_lp;
    pg = gbht_r[gidx_r] > half_lp;
    pred = (chooser_r[idx_r_i] > half_lp) ? pg : pl;
    repair = w_v_i & mispredict_i;
    accept = r_v_i & ~repair;
    ghist_w = meta_i[meta_width_lp-1:2];
    pg_w = meta_i[1];
    pl_w = meta_i[0];
    gidx_w = idx_w_i ^ bht_idx_width_p'(ghist_w);
    // shift-then-OR keeps the single-bit history case legal
    ghr_shift = (ghr_r << 1) | ghist_width_p'(pred);
    ghr_repair = (ghist_w << 1) | ghist_width_p'(taken_i);
  end
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      for (int i = 0; i < entries_lp; i++) begin
        lbht_r[i] <= half_lp;
        gbht_r[i] <= half_lp;
        chooser_r[i] <= half_lp;
      end
      ghr_r <= '0;
      predict_v_o <= 1'b0;
      predict_o <= 1'b0;
      meta_o <= '0;
    end else begin
      predict_v_o <= accept;
      predict_o <= accept & pred;
      if (accept) meta_o <= {ghr_r, pg, pl};
      if (repair) ghr_r <= ghr_repair;
      else if (accept) ghr_r <= ghr_shift;
      if (w_v_i) begin
        lbht_r[idx_w_i] <= sat(lbht_r[idx_w_i], taken_i);
        gbht_r[gidx_w] <= sat(gbht_r[gidx_w], taken_i);
        if (pl_w != pg_w) chooser_r[idx_w_i] <= sat(chooser_r[idx_w_i], pg_w == taken_i);
      end
    end
  end
endmodule

// File: tb/tb_bp_fe_bp_tournament_gshare.sv
// tb_bp_fe_bp_tournament_gshare: directed checks of lookup, training, saturation, history repair, chooser and async reset
module tb_bp_fe_bp_tournament_gshare;
  logic clk = 1'b0, reset_n = 1'b0;
  logic r_v = 1'b0, w_v = 1'b0, taken = 1'b0, misp = 1'b0;
  logic [7:0] idx_r = '0, idx_w = '0;
  logic [9:0] meta_i = '0, meta_o;
  logic pv, p;
  int vectors = 0, miscompares = 0;
  always #5 clk = ~clk;
  bp_fe_bp_tournament_gshare dut (
    .clk_i(clk), .reset_n_i(reset_n), .r_v_i(r_v), .idx_r_i(idx_r),
    .predict_v_o(pv), .predict_o(p), .meta_o(meta_o),
    .w_v_i(w_v), .idx_w_i(idx_w), .taken_i(taken), .mispredict_i(misp), .meta_i(meta_i)
  );
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic lookup(input logic [7:0] idx);
    idx_r = idx; r_v = 1'b1;
    @(posedge clk); #1;
    r_v = 1'b0;
  endtask
  task automatic upd(input logic [7:0] idx, input logic t, input logic m, input logic [7:0] gh, input logic pgv, input logic plv);
    idx_w = idx; taken = t; misp = m; meta_i = {gh, pgv, plv}; w_v = 1'b1;
    @(posedge clk); #1;
    w_v = 1'b0; misp = 1'b0;
  endtask
  initial begin
    repeat (2) @(posedge clk);
    #1;
    chk("rst_pv", pv, 0);
    chk("rst_p", p, 0);
    chk("rst_meta", meta_o, 0);
    reset_n = 1'b1;
    @(posedge clk); #1;
    lookup(8'h10);
    chk("t1_pv", pv, 1);
    chk("t1_p", p, 0);
    chk("t1_meta", meta_o, 10'h000);
    chk("t1_ghr", dut.ghr_r, 8'h00);
    repeat (4) upd(8'h10, 1, 0, 8'h00, 0, 0);
    chk("t2_local", dut.lbht_r[8'h10], 3);
    chk("t2_gshare", dut.gbht_r[8'h10], 3);
    chk("t2_chooser", dut.chooser_r[8'h10], 1);
    lookup(8'h10);
    chk("t2_p", p, 1);
    chk("t2_meta", meta_o, 10'h003);
    repeat (5) upd(8'h10, 1, 0, 8'h00, 0, 0);
    chk("t3_local_sat_hi", dut.lbht_r[8'h10], 3);
    chk("t3_gshare_sat_hi", dut.gbht_r[8'h10], 3);
    repeat (5) upd(8'h10, 0, 0, 8'h00, 0, 0);
    chk("t3_local_sat_lo", dut.lbht_r[8'h10], 0);
    chk("t3_gshare_sat_lo", dut.gbht_r[8'h10], 0);
    upd(8'h50, 0, 1, 8'h00, 0, 0);
    chk("t4_ghr_zeroed", dut.ghr_r, 8'h00);
    repeat (2) upd(8'h40, 1, 0, 8'h00, 0, 0);
    lookup(8'h40);
    chk("t4_l1_p", p, 1);
    chk("t4_l1_meta", meta_o, 10'h003);
    lookup(8'h40);
    lookup(8'h40);
    chk("t4_l3_p", p, 1);
    chk("t4_l3_meta", meta_o, 10'h00D);
    chk("t4_ghr_07", dut.ghr_r, 8'h07);
    idx_r = 8'h40; r_v = 1'b1;
    upd(8'h60, 0, 1, 8'h01, 0, 0);
    r_v = 1'b0;
    chk("t4_kill_pv", pv, 0);
    chk("t4_kill_p", p, 0);
    chk("t4_meta_held", meta_o, 10'h00D);
    chk("t4_ghr_repair", dut.ghr_r, 8'h02);
    chk("t4_local_60", dut.lbht_r[8'h60], 0);
    chk("t4_gshare_61", dut.gbht_r[8'h61], 0);
    lookup(8'h40);
    chk("t4_post_p", p, 1);
    chk("t4_post_meta", meta_o, 10'h009);
    repeat (2) upd(8'h20, 1, 0, 8'h05, 1, 0);
    chk("t5_chooser_3", dut.chooser_r[8'h20], 3);
    chk("t5_gshare_25", dut.gbht_r[8'h25], 3);
    repeat (3) upd(8'h20, 0, 0, 8'h00, 0, 0);
    chk("t5_local_20", dut.lbht_r[8'h20], 0);
    chk("t5_chooser_hold", dut.chooser_r[8'h20], 3);
    lookup(8'h20);
    chk("t5_p_global", p, 1);
    chk("t5_meta", meta_o, 10'h016);
    upd(8'h20, 1, 0, 8'h00, 0, 1);
    chk("t5_chooser_dec", dut.chooser_r[8'h20], 2);
    idx_r = 8'h40; r_v = 1'b1;
    @(posedge clk); #1;
    r_v = 1'b0;
    chk("t6_pv_before", pv, 1);
    #2 reset_n = 1'b0;
    #1;
    chk("t6_pv", pv, 0);
    chk("t6_meta", meta_o, 0);
    chk("t6_ghr", dut.ghr_r, 0);
    chk("t6_local_40", dut.lbht_r[8'h40], 1);
    chk("t6_chooser_20", dut.chooser_r[8'h20], 1);
    @(posedge clk); #1;
    reset_n = 1'b1;
    @(posedge clk); #1;
    lookup(8'h40);
    chk("t6_post_p", p, 0);
    chk("t6_post_meta", meta_o, 10'h000);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
